// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush, load-use
// hazard detection with single-bubble stall, and a saturating stall counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill the instruction entering EX
//   ID_valid / ID_ready   decode-side handshake
//   ID_ctl*, ID_*         control groups, operand data, register specifiers
//   EX_ready / EX_valid   execute-side handshake
//   EX_ctl*, EX_*         registered controls (zero while EX_valid=0), data
//   hazard                load-use hazard detected this cycle
//   stall_cnt             saturating count of hazard cycles

module id_ex_pipe #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int CTLWB_W     = 2,
    parameter int CTLM_W      = 3,
    parameter int CTLEX_W     = 4,
    parameter int MEMRD_BIT   = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,

    input  logic                   ID_valid,
    output logic                   ID_ready,
    input  logic [CTLWB_W-1:0]     ID_ctlwb,
    input  logic [CTLM_W-1:0]      ID_ctlm,
    input  logic [CTLEX_W-1:0]     ID_ctlex,
    input  logic [DATA_W-1:0]      ID_npc,
    input  logic [DATA_W-1:0]      ID_rd1,
    input  logic [DATA_W-1:0]      ID_rd2,
    input  logic [DATA_W-1:0]      ID_imm,
    input  logic [REG_AW-1:0]      ID_rs,
    input  logic [REG_AW-1:0]      ID_rt,
    input  logic [REG_AW-1:0]      ID_rd,

    input  logic                   EX_ready,
    output logic                   EX_valid,
    output logic [CTLWB_W-1:0]     EX_ctlwb,
    output logic [CTLM_W-1:0]      EX_ctlm,
    output logic [CTLEX_W-1:0]     EX_ctlex,
    output logic [DATA_W-1:0]      EX_npc,
    output logic [DATA_W-1:0]      EX_rd1,
    output logic [DATA_W-1:0]      EX_rd2,
    output logic [DATA_W-1:0]      EX_imm,
    output logic [REG_AW-1:0]      EX_rs,
    output logic [REG_AW-1:0]      EX_rt,
    output logic [REG_AW-1:0]      EX_rd,

    output logic                   hazard,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // ---------------------------------------------------------------
    // Stage state
    // ---------------------------------------------------------------
    logic                   valid_q;
    logic [CTLWB_W-1:0]     ctlwb_q;
    logic [CTLM_W-1:0]      ctlm_q;
    logic [CTLEX_W-1:0]     ctlex_q;
    logic [DATA_W-1:0]      npc_q;
    logic [DATA_W-1:0]      rd1_q;
    logic [DATA_W-1:0]      rd2_q;
    logic [DATA_W-1:0]      imm_q;
    logic [REG_AW-1:0]      rs_q;
    logic [REG_AW-1:0]      rt_q;
    logic [REG_AW-1:0]      rd_q;
    logic [STALL_CNT_W-1:0] stall_q;

    // ---------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------
    logic ex_is_load;
    logic rt_nonzero;
    logic rt_match;
    logic capture;
    logic advance;
    logic stall_sat;

    // A load in EX writes rt; a dependent reader in ID must wait one
    // cycle. $zero is never a real dependency.
    assign ex_is_load = valid_q & ctlm_q[MEMRD_BIT];
    assign rt_nonzero = |rt_q;
    assign rt_match   = (rt_q == ID_rs) | (rt_q == ID_rt);
    assign hazard     = ID_valid & ex_is_load & rt_nonzero & rt_match;

    // ID_valid reaches ID_ready only through hazard.
    assign ID_ready   = EX_ready & ~hazard & ~flush;

    // advance: the stage moves this edge (either capture or bubble)
    assign advance    = EX_ready & ~flush;
    assign capture    = advance & ID_valid & ~hazard;

    assign stall_sat  = &stall_q;

    // ---------------------------------------------------------------
    // Valid and control group
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctlwb_q <= '0;
            ctlm_q  <= '0;
            ctlex_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctlwb_q <= '0;
            ctlm_q  <= '0;
            ctlex_q <= '0;
        end else if (EX_ready) begin
            if (capture) begin
                valid_q <= 1'b1;
                ctlwb_q <= ID_ctlwb;
                ctlm_q  <= ID_ctlm;
                ctlex_q <= ID_ctlex;
            end else begin
                // bubble: no valid input or a load-use hazard
                valid_q <= 1'b0;
                ctlwb_q <= '0;
                ctlm_q  <= '0;
                ctlex_q <= '0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Data and specifiers: only written on an actual transfer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npc_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            imm_q <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else if (capture) begin
            npc_q <= ID_npc;
            rd1_q <= ID_rd1;
            rd2_q <= ID_rd2;
            imm_q <= ID_imm;
            rs_q  <= ID_rs;
            rt_q  <= ID_rt;
            rd_q  <= ID_rd;
        end
    end

    // ---------------------------------------------------------------
    // Saturating stall counter (survives flush)
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (hazard && !stall_sat) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Outputs; controls gated so an empty stage can never write
    // ---------------------------------------------------------------
    assign EX_valid  = valid_q;
    assign EX_ctlwb  = ctlwb_q & {CTLWB_W{valid_q}};
    assign EX_ctlm   = ctlm_q  & {CTLM_W{valid_q}};
    assign EX_ctlex  = ctlex_q & {CTLEX_W{valid_q}};
    assign EX_npc    = npc_q;
    assign EX_rd1    = rd1_q;
    assign EX_rd2    = rd2_q;
    assign EX_imm    = imm_q;
    assign EX_rs     = rs_q;
    assign EX_rt     = rt_q;
    assign EX_rd     = rd_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed test-plan steps followed by
// randomized traffic compared against a behavioural slot model.

module tb_id_ex_pipe;

    localparam int SCW = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [3:0]  id_ex;
    logic [31:0] id_npc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_ready;
    logic        ex_valid;
    logic [1:0]  ex_wb;
    logic [2:0]  ex_m;
    logic [3:0]  ex_ex;
    logic [31:0] ex_npc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        hazard;
    logic [SCW-1:0] stall_cnt;

    id_ex_pipe #(.STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ID_valid(id_valid), .ID_ready(id_ready),
        .ID_ctlwb(id_wb), .ID_ctlm(id_m), .ID_ctlex(id_ex),
        .ID_npc(id_npc), .ID_rd1(id_rd1), .ID_rd2(id_rd2), .ID_imm(id_imm),
        .ID_rs(id_rs), .ID_rt(id_rt), .ID_rd(id_rd),
        .EX_ready(ex_ready), .EX_valid(ex_valid),
        .EX_ctlwb(ex_wb), .EX_ctlm(ex_m), .EX_ctlex(ex_ex),
        .EX_npc(ex_npc), .EX_rd1(ex_rd1), .EX_rd2(ex_rd2), .EX_imm(ex_imm),
        .EX_rs(ex_rs), .EX_rt(ex_rt), .EX_rd(ex_rd),
        .hazard(hazard), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference: what instruction occupies the EX slot, and how many
    // hazard cycles have been seen since reset.
    typedef struct packed {
        logic        v;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } slot_t;

    slot_t slot;
    int    haz_seen;
    int    pass_n = 0;
    int    fail_n = 0;
    int    total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard();
        // older load writing a real register that the new instruction reads
        return id_valid && slot.v && slot.m[1] && slot.rt != 0 &&
               (slot.rt == id_rs || slot.rt == id_rt);
    endfunction

    function automatic int exp_cnt();
        return (haz_seen > 3) ? 3 : haz_seen;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".valid"}, 64'(ex_valid), 64'(slot.v));
        chk({tag, ".wb"},    64'(ex_wb),    64'(slot.v ? slot.wb : 2'd0));
        chk({tag, ".m"},     64'(ex_m),     64'(slot.v ? slot.m : 3'd0));
        chk({tag, ".ex"},    64'(ex_ex),    64'(slot.v ? slot.ex : 4'd0));
        chk({tag, ".npc"},   64'(ex_npc),   64'(slot.npc));
        chk({tag, ".rd1"},   64'(ex_rd1),   64'(slot.rd1));
        chk({tag, ".rd2"},   64'(ex_rd2),   64'(slot.rd2));
        chk({tag, ".imm"},   64'(ex_imm),   64'(slot.imm));
        chk({tag, ".rs"},    64'(ex_rs),    64'(slot.rs));
        chk({tag, ".rt"},    64'(ex_rt),    64'(slot.rt));
        chk({tag, ".rd"},    64'(ex_rd),    64'(slot.rd));
        chk({tag, ".cnt"},   64'(stall_cnt), 64'(exp_cnt()));
    endtask

    // One clock: check combinational outputs, clock, update model, check.
    bit last_ready;
    task automatic step(input string tag);
        bit h;
        #1;
        h = model_hazard();
        last_ready = ex_ready && !h && !flush;
        chk({tag, ".haz"},   64'(hazard),   64'(h));
        chk({tag, ".ready"}, 64'(id_ready), 64'(last_ready));
        @(posedge clk);
        if (h) haz_seen++;
        if (flush) begin
            slot.v = 0; slot.wb = 0; slot.m = 0; slot.ex = 0;
        end else if (!ex_ready) begin
            // EX stalled: slot keeps its contents
        end else if (id_valid && !h) begin
            slot = '{1'b1, id_wb, id_m, id_ex, id_npc, id_rd1, id_rd2,
                     id_imm, id_rs, id_rt, id_rd};
        end else begin
            slot.v = 0; slot.wb = 0; slot.m = 0; slot.ex = 0;
        end
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        slot = '0;
        haz_seen = 0;
        check_outs(tag);
        #2 rst_n = 1'b1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] wb,
                          input logic [2:0] m, input logic [3:0] ex,
                          input logic [31:0] npc, input logic [31:0] rd1,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_valid = v; id_wb = wb; id_m = m; id_ex = ex;
        id_npc = npc; id_rd1 = rd1; id_rd2 = $urandom; id_imm = $urandom;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic rand_id();
        set_id($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
               4'($urandom), $urandom, $urandom,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom));
    endtask

    initial begin
        slot = '0;
        haz_seen = 0;
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs("init");

        // Pass-through
        set_id(1, 2'b11, 3'b000, 4'h5, 32'h0040_0004, 32'h1234_5678,
               5'd1, 5'd2, 5'd3);
        step("pass");
        chk("pass.npc_k", 64'(ex_npc), 64'h0040_0004);
        chk("pass.rd1_k", 64'(ex_rd1), 64'h1234_5678);
        chk("pass.wb_k",  64'(ex_wb),  64'd3);
        chk("pass.v_k",   64'(ex_valid), 64'd1);

        // Asynchronous reset mid-cycle while EX holds a valid instruction
        do_reset("rst");
        chk("rst.valid_k", 64'(ex_valid), 64'd0);

        // Load-use hazard: load writing r8, then a reader of r8
        set_id(1, 2'b01, 3'b010, 4'h1, 32'h100, 32'h1, 5'd4, 5'd8, 5'd0);
        step("ld");
        set_id(1, 2'b10, 3'b000, 4'h2, 32'h104, 32'h2, 5'd8, 5'd9, 5'd10);
        step("lu1");
        chk("lu1.valid_k", 64'(ex_valid), 64'd0);
        step("lu2");
        chk("lu2.rs_k",  64'(ex_rs), 64'd8);
        chk("lu2.cnt_k", 64'(stall_cnt), 64'd1);

        // Load into $zero never stalls
        set_id(1, 2'b01, 3'b010, 4'h1, 32'h108, 32'h3, 5'd0, 5'd0, 5'd0);
        step("z0");
        set_id(1, 2'b11, 3'b001, 4'h3, 32'h10c, 32'h4, 5'd7, 5'd0, 5'd6);
        step("z1");
        chk("z1.npc_k", 64'(ex_npc), 64'h10c);

        // Backpressure three cycles, then flush while still stalled
        ex_ready = 1'b0;
        set_id(1, 2'b10, 3'b100, 4'h4, 32'h110, 32'h5, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) step("bp");
        chk("bp.npc_k", 64'(ex_npc), 64'h10c);
        flush = 1'b1;
        step("fl");
        chk("fl.m_k", 64'(ex_m), 64'd0);
        flush = 1'b0;
        ex_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle");

        // Saturation: held hazard under backpressure, count 1,2,3,3,3
        do_reset("rst2");
        set_id(1, 2'b01, 3'b010, 4'h0, 32'h200, 32'h6, 5'd1, 5'd5, 5'd0);
        step("sld");
        ex_ready = 1'b0;
        set_id(1, 2'b10, 3'b000, 4'h0, 32'h204, 32'h7, 5'd5, 5'd2, 5'd3);
        for (int i = 0; i < 5; i++) begin
            step("sat");
            chk("sat.cnt_k", 64'(stall_cnt), 64'((i < 3) ? i + 1 : 3));
        end
        ex_ready = 1'b1;

        // Flush simultaneous with a hazard: flush wins, hazard counts
        do_reset("rst3");
        set_id(1, 2'b01, 3'b010, 4'h0, 32'h300, 32'h8, 5'd1, 5'd6, 5'd0);
        step("fhl");
        set_id(1, 2'b10, 3'b000, 4'h0, 32'h304, 32'h9, 5'd6, 5'd2, 5'd3);
        flush = 1'b1;
        step("fh");
        chk("fh.cnt_k", 64'(stall_cnt), 64'd1);
        flush = 1'b0;

        // Randomized traffic; decode holds while not accepted
        rand_id();
        for (int n = 0; n < 600; n++) begin
            ex_ready = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 11) == 0;
            step("rnd");
            if (n % 97 == 96) do_reset("rrst");
            if (!(id_valid && !last_ready)) rand_id();
        end

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end

endmodule
